// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and helpers for the CDB arbiter slice.
// Holds the default build widths and the round-robin pointer advance rule.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_ROB_DEPTH  = 64;
  localparam int CDB_NUM_REQ    = 4;

  // Explicit wrap compare so non-power-of-two requester counts work.
  function automatic int rr_next(input int k, input int n);
    return (k >= n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester result ports and CDB broadcast bundle between functional units and the arbiter.
// The slave side is the arbiter, the master side the functional units / snoopers.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = CDB_NUM_REQ,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int ROB_DEPTH  = CDB_ROB_DEPTH
);
  localparam int TAG_WIDTH = $clog2(ROB_DEPTH);

  logic                                 i_flush;
  logic [NUM_REQ-1:0]                   i_req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_data;
  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]    i_req_tag;
  logic [NUM_REQ-1:0]                   i_req_exc;
  logic [NUM_REQ-1:0]                   i_req_branch;
  logic [NUM_REQ-1:0]                   o_req_ready;
  logic                                 o_cdb_en;
  logic [DATA_WIDTH-1:0]                o_cdb_data;
  logic [TAG_WIDTH-1:0]                 o_cdb_tag;
  logic                                 o_cdb_exc;
  logic                                 o_cdb_branch;

  modport slave (
    input  i_flush, i_req_valid, i_req_data, i_req_tag, i_req_exc, i_req_branch,
    output o_req_ready, o_cdb_en, o_cdb_data, o_cdb_tag, o_cdb_exc, o_cdb_branch
  );

  modport master (
    output i_flush, i_req_valid, i_req_data, i_req_tag, i_req_exc, i_req_branch,
    input  o_req_ready, o_cdb_en, o_cdb_data, o_cdb_tag, o_cdb_exc, o_cdb_branch
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate valids so i_ptr sits at bit 0,
// priority-encode the lowest set bit, then map back to an absolute index.
module rr_picker #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  localparam int SW = PW + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  always_comb begin
    rot   = N'({i_valid, i_valid} >> i_ptr);
    o_any = |i_valid;
    sum   = {1'b0, i_ptr};
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sum = {1'b0, i_ptr} + SW'(j);
    end
    if (sum >= SW'(N)) sum = sum - SW'(N);
    o_idx   = sum[PW-1:0];
    o_grant = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus: grants one result per cycle
// and broadcasts it from an output register the following cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int ROB_DEPTH  = CDB_ROB_DEPTH,
  parameter int NUM_REQ    = CDB_NUM_REQ
) (
  input logic          clk,
  input logic          n_rst,
  cdb_arbiter_if.slave bus
);
  localparam int TAG_WIDTH = $clog2(ROB_DEPTH);
  localparam int PTR_WIDTH = $clog2(NUM_REQ);

  // Kept local so the packet widths follow this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  exc;
    logic                  branch;
  } cdb_pkt_t;

  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                 cdb_en_q, cdb_en_d;
  cdb_pkt_t             pkt_q, pkt_d;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_WIDTH-1:0] win_idx;
  logic                 win_any;
  logic                 xfer;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_valid (bus.i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_grant (grant),
    .o_idx   (win_idx),
    .o_any   (win_any)
  );

  always_comb begin
    xfer            = win_any && !bus.i_flush && n_rst;
    bus.o_req_ready = xfer ? grant : '0;
    cdb_en_d        = xfer;
    pkt_d           = pkt_q;
    rr_ptr_d        = rr_ptr_q;
    if (bus.i_flush) rr_ptr_d = '0;
    else if (xfer)   rr_ptr_d = PTR_WIDTH'(rr_next(int'(win_idx), NUM_REQ));
    if (xfer) begin
      pkt_d.data   = bus.i_req_data[win_idx];
      pkt_d.tag    = bus.i_req_tag[win_idx];
      pkt_d.exc    = bus.i_req_exc[win_idx];
      pkt_d.branch = bus.i_req_branch[win_idx];
    end
  end

  // Output register: payload holds its last value on idle cycles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr_q <= '0;
      cdb_en_q <= 1'b0;
      pkt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_en_q <= cdb_en_d;
      pkt_q    <= pkt_d;
    end
  end

  assign bus.o_cdb_en     = cdb_en_q;
  assign bus.o_cdb_data   = pkt_q.data;
  assign bus.o_cdb_tag    = pkt_q.tag;
  assign bus.o_cdb_exc    = pkt_q.exc;
  assign bus.o_cdb_branch = pkt_q.branch;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-requester instance and a 3-requester wrap instance.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic n_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  cdb_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ROB_DEPTH(64)) bus ();
  cdb_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32), .ROB_DEPTH(64)) bus3 ();

  cdb_arbiter #(.DATA_WIDTH(32), .ROB_DEPTH(64), .NUM_REQ(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  cdb_arbiter #(.DATA_WIDTH(32), .ROB_DEPTH(64), .NUM_REQ(3)) dut3 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic v, input logic [31:0] d, input logic [5:0] t,
                     input logic e, input logic b);
    bus.i_req_valid[k]  = v;
    bus.i_req_data[k]   = d;
    bus.i_req_tag[k]    = t;
    bus.i_req_exc[k]    = e;
    bus.i_req_branch[k] = b;
  endtask

  task automatic drv3(input int k, input logic v, input logic [5:0] t);
    bus3.i_req_valid[k]  = v;
    bus3.i_req_data[k]   = 32'hC000_0000 + 32'(k);
    bus3.i_req_tag[k]    = t;
    bus3.i_req_exc[k]    = 1'b0;
    bus3.i_req_branch[k] = 1'b0;
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.i_flush   = 1'b0;
    bus3.i_flush  = 1'b0;
    bus3.i_req_valid = '0; bus3.i_req_data = '0; bus3.i_req_tag = '0;
    bus3.i_req_exc   = '0; bus3.i_req_branch = '0;
    for (int k = 0; k < 4; k++) drv(k, 1'b1, 32'hA000_0000 + 32'(k), 6'(10 + k), 1'b0, 1'b0);

    // Reset held with every requester valid
    cyc(); cyc();
    chk("rst_en",    64'(bus.o_cdb_en),    64'h0);
    chk("rst_ready", 64'(bus.o_req_ready), 64'h0);
    chk("rst_tag",   64'(bus.o_cdb_tag),   64'h0);
    chk("rst_data",  64'(bus.o_cdb_data),  64'h0);
    n_rst = 1'b1;
    #1;
    chk("rr_ready0", 64'(bus.o_req_ready), 64'h1);

    // All four valid: grants 0,1,2,3,0
    cyc(); #1;
    chk("rr_en0",    64'(bus.o_cdb_en),    64'h1);
    chk("rr_tag0",   64'(bus.o_cdb_tag),   64'd10);
    chk("rr_data0",  64'(bus.o_cdb_data),  64'hA000_0000);
    chk("rr_ready1", 64'(bus.o_req_ready), 64'h2);
    cyc(); #1;
    chk("rr_tag1",   64'(bus.o_cdb_tag),   64'd11);
    chk("rr_ready2", 64'(bus.o_req_ready), 64'h4);
    cyc(); #1;
    chk("rr_tag2",   64'(bus.o_cdb_tag),   64'd12);
    chk("rr_ready3", 64'(bus.o_req_ready), 64'h8);
    cyc(); #1;
    chk("rr_tag3",   64'(bus.o_cdb_tag),   64'd13);
    chk("rr_en3",    64'(bus.o_cdb_en),    64'h1);
    chk("rr_ready4", 64'(bus.o_req_ready), 64'h1);
    cyc();
    for (int k = 0; k < 4; k++) drv(k, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("rr_tag4",   64'(bus.o_cdb_tag),   64'd10);
    chk("rr_en4",    64'(bus.o_cdb_en),    64'h1);
    chk("idle_ready",64'(bus.o_req_ready), 64'h0);
    cyc(); #1;
    chk("idle_en",   64'(bus.o_cdb_en),    64'h0);
    chk("idle_hold", 64'(bus.o_cdb_tag),   64'd10);

    // Single requester 2 (rr_ptr=1)
    drv(2, 1'b1, 32'hDEAD_BEEF, 6'd5, 1'b0, 1'b0);
    #1;
    chk("single_ready", 64'(bus.o_req_ready), 64'h4);
    cyc();
    drv(2, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("single_en",   64'(bus.o_cdb_en),   64'h1);
    chk("single_tag",  64'(bus.o_cdb_tag),  64'd5);
    chk("single_data", 64'(bus.o_cdb_data), 64'hDEAD_BEEF);
    cyc(); #1;
    chk("single_off",  64'(bus.o_cdb_en),   64'h0);
    chk("single_hold", 64'(bus.o_cdb_data), 64'hDEAD_BEEF);

    // Wrap/skip from rr_ptr=3 with req1, req3; req3 carries exc
    drv(1, 1'b1, 32'h1111_0001, 6'd9, 1'b0, 1'b0);
    drv(3, 1'b1, 32'h3333_0003, 6'd7, 1'b1, 1'b0);
    #1;
    chk("wrap_ready3", 64'(bus.o_req_ready), 64'h8);
    cyc();
    drv(3, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("wrap_tag3",   64'(bus.o_cdb_tag),    64'd7);
    chk("exc_flag",    64'(bus.o_cdb_exc),    64'h1);
    chk("exc_branch",  64'(bus.o_cdb_branch), 64'h0);
    chk("wrap_ready1", 64'(bus.o_req_ready),  64'h2);
    cyc();
    drv(1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("wrap_tag1",   64'(bus.o_cdb_tag),    64'd9);
    chk("exc_clear",   64'(bus.o_cdb_exc),    64'h0);
    chk("wrap_idle",   64'(bus.o_req_ready),  64'h0);

    // Flush: req1 accepted from rr_ptr=2, then flush with req0/req2 pending
    cyc();
    drv(1, 1'b1, 32'h0000_5151, 6'd20, 1'b0, 1'b0);
    #1;
    chk("fl_ready1", 64'(bus.o_req_ready), 64'h2);
    cyc();
    drv(1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    drv(0, 1'b1, 32'h0000_5050, 6'd21, 1'b0, 1'b0);
    drv(2, 1'b1, 32'h0000_5252, 6'd22, 1'b0, 1'b1);
    bus.i_flush = 1'b1;
    #1;
    chk("fl_ready0", 64'(bus.o_req_ready), 64'h0);
    chk("fl_inflt",  64'(bus.o_cdb_en),    64'h1);
    chk("fl_tag",    64'(bus.o_cdb_tag),   64'd20);
    cyc();
    bus.i_flush = 1'b0;
    #1;
    chk("fl_en_off", 64'(bus.o_cdb_en),    64'h0);
    chk("fl_ptr0",   64'(bus.o_req_ready), 64'h1);
    cyc();
    drv(0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("fl_tag0",   64'(bus.o_cdb_tag),   64'd21);
    chk("fl_ready2", 64'(bus.o_req_ready), 64'h4);
    cyc();
    drv(2, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("br_tag",    64'(bus.o_cdb_tag),    64'd22);
    chk("br_flag",   64'(bus.o_cdb_branch), 64'h1);
    chk("br_en",     64'(bus.o_cdb_en),     64'h1);

    // Asynchronous reset while broadcasting
    n_rst = 1'b0;
    #1;
    chk("arst_en",   64'(bus.o_cdb_en),     64'h0);
    chk("arst_tag",  64'(bus.o_cdb_tag),    64'h0);
    chk("arst_br",   64'(bus.o_cdb_branch), 64'h0);
    cyc();
    n_rst = 1'b1;

    // NUM_REQ=3: grant from 2 must wrap to 0
    cyc();
    drv3(2, 1'b1, 6'd2);
    #1;
    chk("n3_ready2", 64'(bus3.o_req_ready), 64'h4);
    cyc();
    drv3(2, 1'b0, 6'd0);
    drv3(0, 1'b1, 6'd30);
    drv3(1, 1'b1, 6'd31);
    #1;
    chk("n3_tag2",   64'(bus3.o_cdb_tag),   64'd2);
    chk("n3_wrap0",  64'(bus3.o_req_ready), 64'h1);
    cyc();
    drv3(0, 1'b0, 6'd0);
    #1;
    chk("n3_tag0",   64'(bus3.o_cdb_tag),   64'd30);
    chk("n3_ready1", 64'(bus3.o_req_ready), 64'h2);
    cyc();
    drv3(1, 1'b0, 6'd0);
    #1;
    chk("n3_tag1",   64'(bus3.o_cdb_tag),   64'd31);
    chk("n3_en",     64'(bus3.o_cdb_en),    64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
